// File: rtl/systolic_job_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_job_scheduler
//   Queues matmul job descriptors from the host and launches them one at a
//   time on the systolic controller. Watches controller done/overflow/cycle
//   count, publishes one status record per job and enforces a watchdog.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   job_valid/job_ready       host descriptor handshake (job_ready = FIFO not full)
//   job_addr_a/b/c, job_n     descriptor base addresses and matrix size
//   flush                     drop all queued (not running) jobs
//   timeout_cyc               watchdog limit, 0 disables
//   ctrl_new_data             1-cycle launch pulse to the controller
//   ctrl_addr_a/b/c, ctrl_n   descriptor of the current job, held until next pop
//   ctrl_done/overflow/cycles controller status inputs
//   busy                      a job is in flight
//   q_count                   queued jobs, running job excluded
//   stat_valid/id/cycles/ovf/err  per-job retire record (err: 0 ok, 1 bad n, 2 timeout)
// ---------------------------------------------------------------------------
module systolic_job_scheduler #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned N      = 4,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned CYC_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [ADDR_W-1:0]       job_addr_a,
   input  logic [ADDR_W-1:0]       job_addr_b,
   input  logic [ADDR_W-1:0]       job_addr_c,
   input  logic [3:0]              job_n,
   input  logic                    flush,
   input  logic [CYC_W-1:0]        timeout_cyc,
   output logic                    ctrl_new_data,
   output logic [ADDR_W-1:0]       ctrl_addr_a,
   output logic [ADDR_W-1:0]       ctrl_addr_b,
   output logic [ADDR_W-1:0]       ctrl_addr_c,
   output logic [3:0]              ctrl_n,
   input  logic                    ctrl_done,
   input  logic                    ctrl_overflow,
   input  logic [CYC_W-1:0]        ctrl_cycles,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  q_count,
   output logic                    stat_valid,
   output logic [7:0]              stat_id,
   output logic [CYC_W-1:0]        stat_cycles,
   output logic                    stat_ovf,
   output logic [1:0]              stat_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [3:0]  N_MAX = 4'(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_ACK,
      S_RUN,
      S_REPORT,
      S_HANG
   } state_t;

   state_t state, state_nx;

   // ---------------- job FIFO ----------------
   logic [ADDR_W-1:0] mem_a  [DEPTH];
   logic [ADDR_W-1:0] mem_b  [DEPTH];
   logic [ADDR_W-1:0] mem_c  [DEPTH];
   logic [3:0]        mem_n  [DEPTH];
   logic [7:0]        mem_id [DEPTH];

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [7:0]        id_ctr;
   logic              full, empty, push, pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign job_ready = ~full;
   assign q_count   = count;
   // flush wins over a same-cycle push; the offered job is simply dropped
   assign push      = job_valid & job_ready & ~flush;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= job_addr_a;
         mem_b[wr_ptr]  <= job_addr_b;
         mem_c[wr_ptr]  <= job_addr_c;
         mem_n[wr_ptr]  <= job_n;
         mem_id[wr_ptr] <= id_ctr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       id_ctr <= '0;
      else if (push) id_ctr <= id_ctr + 8'd1;
   end

   // ---------------- scheduler FSM ----------------
   logic [3:0]       head_n;
   logic             head_legal;
   logic [CYC_W-1:0] wdog;
   logic [7:0]       cur_id;
   logic             to_hit;
   logic             reject, wd_tick, rpt_ok, rpt_to;

   assign head_n     = mem_n[rd_ptr];
   assign head_legal = (head_n != 4'd0) && (head_n <= N_MAX);
   assign to_hit     = (timeout_cyc != '0) && (wdog == timeout_cyc);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      pop           = 1'b0;
      reject        = 1'b0;
      ctrl_new_data = 1'b0;
      wd_tick       = 1'b0;
      rpt_ok        = 1'b0;
      rpt_to        = 1'b0;
      case (state)
         S_IDLE: begin
            // a head entry being flushed this cycle is treated as dropped
            if (!empty && !flush) begin
               pop = 1'b1;
               if (head_legal) state_nx = S_LAUNCH;
               else            reject   = 1'b1;
            end
         end
         S_LAUNCH: begin
            ctrl_new_data = 1'b1;
            state_nx      = S_ACK;
         end
         S_ACK: begin
            if (to_hit) begin
               rpt_to   = 1'b1;
               state_nx = S_HANG;
            end else begin
               wd_tick = 1'b1;
               if (!ctrl_done) state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (to_hit) begin
               rpt_to   = 1'b1;
               state_nx = S_HANG;
            end else begin
               wd_tick = 1'b1;
               if (ctrl_done) state_nx = S_REPORT;
            end
         end
         S_REPORT: begin
            rpt_ok   = 1'b1;
            state_nx = S_IDLE;
         end
         S_HANG:  state_nx = S_HANG;
         default: state_nx = S_IDLE;
      endcase
   end

   // descriptor registers, watchdog and status record
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_addr_a <= '0;
         ctrl_addr_b <= '0;
         ctrl_addr_c <= '0;
         ctrl_n      <= '0;
         cur_id      <= '0;
         wdog        <= '0;
         stat_valid  <= 1'b0;
         stat_id     <= '0;
         stat_cycles <= '0;
         stat_ovf    <= 1'b0;
         stat_err    <= '0;
      end else begin
         stat_valid <= 1'b0;
         if (pop) begin
            ctrl_addr_a <= mem_a[rd_ptr];
            ctrl_addr_b <= mem_b[rd_ptr];
            ctrl_addr_c <= mem_c[rd_ptr];
            ctrl_n      <= head_n;
            cur_id      <= mem_id[rd_ptr];
         end
         if (reject) begin
            stat_valid  <= 1'b1;
            stat_id     <= mem_id[rd_ptr];
            stat_cycles <= '0;
            stat_ovf    <= 1'b0;
            stat_err    <= 2'd1;
         end
         if (ctrl_new_data) wdog <= '0;
         if (wd_tick)       wdog <= wdog + 1'b1;
         if (rpt_ok) begin
            stat_valid  <= 1'b1;
            stat_id     <= cur_id;
            stat_cycles <= ctrl_cycles;
            stat_ovf    <= ctrl_overflow;
            stat_err    <= 2'd0;
         end
         if (rpt_to) begin
            stat_valid  <= 1'b1;
            stat_id     <= cur_id;
            stat_cycles <= wdog;
            stat_ovf    <= ctrl_overflow;
            stat_err    <= 2'd2;
         end
      end
   end

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_systolic_job_scheduler
//   Directed bench for systolic_job_scheduler with a small behavioural model
//   of the systolic controller (done level, cycle counter, stall control).
// ---------------------------------------------------------------------------
module tb_systolic_job_scheduler;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned N      = 4;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned CYC_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              job_valid = 1'b0;
   logic              job_ready;
   logic [ADDR_W-1:0] job_addr_a = '0, job_addr_b = '0, job_addr_c = '0;
   logic [3:0]        job_n = '0;
   logic              flush = 1'b0;
   logic [CYC_W-1:0]  timeout_cyc = '0;
   logic              ctrl_new_data;
   logic [ADDR_W-1:0] ctrl_addr_a, ctrl_addr_b, ctrl_addr_c;
   logic [3:0]        ctrl_n;
   logic              ctrl_done;
   logic              ctrl_overflow = 1'b0;
   logic [CYC_W-1:0]  ctrl_cycles;
   logic              busy;
   logic [2:0]        q_count;
   logic              stat_valid;
   logic [7:0]        stat_id;
   logic [CYC_W-1:0]  stat_cycles;
   logic              stat_ovf;
   logic [1:0]        stat_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   systolic_job_scheduler #(
      .DEPTH (DEPTH),
      .N     (N),
      .ADDR_W(ADDR_W),
      .CYC_W (CYC_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_addr_a   (job_addr_a),
      .job_addr_b   (job_addr_b),
      .job_addr_c   (job_addr_c),
      .job_n        (job_n),
      .flush        (flush),
      .timeout_cyc  (timeout_cyc),
      .ctrl_new_data(ctrl_new_data),
      .ctrl_addr_a  (ctrl_addr_a),
      .ctrl_addr_b  (ctrl_addr_b),
      .ctrl_addr_c  (ctrl_addr_c),
      .ctrl_n       (ctrl_n),
      .ctrl_done    (ctrl_done),
      .ctrl_overflow(ctrl_overflow),
      .ctrl_cycles  (ctrl_cycles),
      .busy         (busy),
      .q_count      (q_count),
      .stat_valid   (stat_valid),
      .stat_id      (stat_id),
      .stat_cycles  (stat_cycles),
      .stat_ovf     (stat_ovf),
      .stat_err     (stat_err)
   );

   // controller model: done drops on launch, rises after m_lat running cycles
   logic             m_done;
   logic [CYC_W-1:0] m_cyc;
   int               m_left;
   int               m_lat   = 40;
   logic             m_stall = 1'b0;

   assign ctrl_done   = m_done;
   assign ctrl_cycles = m_cyc;

   always @(posedge clk) begin
      if (rst) begin
         m_done <= 1'b1;
         m_cyc  <= '0;
         m_left <= 0;
      end else if (ctrl_new_data) begin
         m_done <= 1'b0;
         m_cyc  <= '0;
         m_left <= m_lat;
      end else if (!m_done && !m_stall) begin
         m_cyc  <= m_cyc + 1'b1;
         m_left <= m_left - 1;
         if (m_left == 1) m_done <= 1'b1;
      end
   end

   // launch counter and retire-record capture {err, ovf, id, cycles}
   int          launches;
   logic [26:0] rec [0:15];
   int          rec_wr;
   int          rec_rd = 0;

   always @(posedge clk) begin
      if (rst) begin
         launches <= 0;
         rec_wr   <= 0;
      end else begin
         if (ctrl_new_data) launches <= launches + 1;
         if (stat_valid && rec_wr < 16) begin
            rec[rec_wr] <= {stat_err, stat_ovf, stat_id, stat_cycles};
            rec_wr      <= rec_wr + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic get_rec(input string tag, input int budget, output logic [26:0] r);
      int i;
      i = 0;
      while (rec_rd >= rec_wr && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      checks++;
      assert (rec_rd < rec_wr) else begin
         errors++;
         $display("FAIL %s: no status record within %0d cycles (observed 0 expected 1)", tag, budget);
         $error("check %s", tag);
      end
      if (rec_rd < rec_wr) begin
         r = rec[rec_rd];
         rec_rd++;
      end else begin
         r = '1;
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      job_valid = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      rec_rd = 0;
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] c, input logic [3:0] n);
      job_valid  = 1'b1;
      job_addr_a = a;
      job_addr_b = b;
      job_addr_c = c;
      job_n      = n;
      @(posedge clk); #1;
      job_valid  = 1'b0;
   endtask

   logic [26:0] r;

   initial begin
      // ---- reset state ----
      do_reset();
      chk("rst_job_ready", job_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_q_count", q_count, 0);
      chk("rst_stat_valid", stat_valid, 0);
      chk("rst_new_data", ctrl_new_data, 0);
      chk("rst_stat_err", stat_err, 0);
      chk("rst_ctrl_addr_b", ctrl_addr_b, 0);

      // ---- single job, 40-cycle controller ----
      m_lat = 40;
      push(12'd0, 12'd16, 12'd32, 4'd4);
      @(posedge clk); #1;                       // pop edge -> LAUNCH
      chk("t1_new_data", ctrl_new_data, 1);
      chk("t1_q_count", q_count, 0);
      chk("t1_busy", busy, 1);
      chk("t1_addr_b", ctrl_addr_b, 16);
      chk("t1_addr_c", ctrl_addr_c, 32);
      chk("t1_n", ctrl_n, 4);
      repeat (20) @(posedge clk); #1;
      chk("t1_mid_addr_a", ctrl_addr_a, 0);
      chk("t1_mid_addr_b", ctrl_addr_b, 16);
      chk("t1_mid_addr_c", ctrl_addr_c, 32);
      chk("t1_mid_new_data", ctrl_new_data, 0);
      get_rec("t1_rec", 100, r);
      chk("t1_id", r[23:16], 0);
      chk("t1_cycles", r[15:0], 40);
      chk("t1_err", r[26:25], 0);
      chk("t1_ovf", r[24], 0);
      chk("t1_launches", launches, 1);
      chk("t1_stat_hold", stat_cycles, 40);
      chk("t1_idle", busy, 0);
      chk("t1_addr_c_hold", ctrl_addr_c, 32);

      // ---- fill FIFO behind a stalled job ----
      do_reset();
      m_stall = 1'b1;
      m_lat   = 5;
      for (int i = 0; i < 5; i++) push(12'(i * 16), 12'(i * 16 + 1), 12'(i * 16 + 2), 4'd2);
      chk("t2_q_full", q_count, 4);
      chk("t2_ready_low", job_ready, 0);
      chk("t2_busy", busy, 1);
      job_valid = 1'b1;
      job_n     = 4'd3;
      repeat (3) @(posedge clk); #1;
      job_valid = 1'b0;
      chk("t2_q_blocked", q_count, 4);
      chk("t2_launch_once", launches, 1);
      m_stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         get_rec("t2_rec", 60, r);
         chk("t2_id", r[23:16], 32'(k));
         chk("t2_cycles", r[15:0], 5);
         chk("t2_err", r[26:25], 0);
      end
      chk("t2_launches", launches, 5);
      chk("t2_q_empty", q_count, 0);
      chk("t2_ready_high", job_ready, 1);

      // ---- illegal sizes n=0, n=5 then legal n=3 ----
      do_reset();
      m_lat = 7;
      push(12'd1, 12'd2, 12'd3, 4'd0);
      push(12'd4, 12'd5, 12'd6, 4'd5);
      push(12'd100, 12'd200, 12'd300, 4'd3);
      get_rec("t3_rec0", 10, r);
      chk("t3_id0", r[23:16], 0);
      chk("t3_err0", r[26:25], 1);
      chk("t3_cyc0", r[15:0], 0);
      chk("t3_ovf0", r[24], 0);
      get_rec("t3_rec1", 10, r);
      chk("t3_id1", r[23:16], 1);
      chk("t3_err1", r[26:25], 1);
      chk("t3_no_launch_yet", launches, 0);
      chk("t3_launch_now", ctrl_new_data, 1);
      get_rec("t3_rec2", 40, r);
      chk("t3_id2", r[23:16], 2);
      chk("t3_err2", r[26:25], 0);
      chk("t3_cyc2", r[15:0], 7);
      chk("t3_launches", launches, 1);
      chk("t3_ctrl_n", ctrl_n, 3);
      chk("t3_ctrl_a", ctrl_addr_a, 100);

      // ---- watchdog timeout ----
      do_reset();
      timeout_cyc = 16'd20;
      m_stall     = 1'b1;
      m_lat       = 5;
      push(12'd4, 12'd8, 12'd12, 4'd2);
      get_rec("t4_rec", 60, r);
      chk("t4_err", r[26:25], 2);
      chk("t4_cycles", r[15:0], 20);
      chk("t4_id", r[23:16], 0);
      chk("t4_busy", busy, 1);
      push(12'd5, 12'd9, 12'd13, 4'd3);
      repeat (30) @(posedge clk); #1;
      chk("t4_no_relaunch", launches, 1);
      chk("t4_q_held", q_count, 1);
      chk("t4_still_busy", busy, 1);
      chk("t4_no_more_recs", rec_wr, 1);
      timeout_cyc = '0;
      m_stall     = 1'b0;

      // ---- flush with same-cycle push while a job runs ----
      do_reset();
      m_stall = 1'b1;
      m_lat   = 4;
      for (int i = 0; i < 4; i++) push(12'(10 * i), 12'd0, 12'd0, 4'd2);
      chk("t5_q3", q_count, 3);
      flush      = 1'b1;
      job_valid  = 1'b1;
      job_addr_a = 12'h55;
      job_n      = 4'd2;
      @(posedge clk); #1;
      flush     = 1'b0;
      job_valid = 1'b0;
      chk("t5_q_flushed", q_count, 0);
      chk("t5_ready", job_ready, 1);
      chk("t5_busy", busy, 1);
      m_stall = 1'b0;
      get_rec("t5_rec", 40, r);
      chk("t5_id", r[23:16], 0);
      chk("t5_err", r[26:25], 0);
      chk("t5_cycles", r[15:0], 4);
      repeat (20) @(posedge clk); #1;
      chk("t5_launches", launches, 1);
      chk("t5_no_more_recs", rec_wr, 1);
      chk("t5_idle", busy, 0);
      push(12'd7, 12'd7, 12'd7, 4'd1);
      get_rec("t5_rec_next", 40, r);
      chk("t5_next_id", r[23:16], 4);
      chk("t5_next_cycles", r[15:0], 4);
      chk("t5_next_addr_a", ctrl_addr_a, 7);

      // ---- overflow reporting ----
      do_reset();
      m_lat         = 6;
      ctrl_overflow = 1'b1;
      push(12'd1, 12'd2, 12'd3, 4'd4);
      get_rec("t6_rec0", 40, r);
      chk("t6_ovf1", r[24], 1);
      chk("t6_cyc0", r[15:0], 6);
      chk("t6_id0", r[23:16], 0);
      ctrl_overflow = 1'b0;
      push(12'd4, 12'd5, 12'd6, 4'd2);
      get_rec("t6_rec1", 40, r);
      chk("t6_ovf0", r[24], 0);
      chk("t6_id1", r[23:16], 1);
      chk("t6_stat_ovf_out", stat_ovf, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
